mor1kx_wb_arbiter: RTL and testbench
====================================

Name: mor1kx_wb_arbiter

Overview:
- Two-master to one-slave Wishbone B3 arbiter that sits directly downstream of the processor top level.
- Merges the instruction (iwbm_*) and data (dwbm_*) master ports onto a single system Wishbone bus.
- A grant is held for a master's full cyc period, so bursts and lock sequences are never split.
- A watchdog terminates hung slave cycles with an error.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- ARB_POLICY, "ROUND_ROBIN", "ROUND_ROBIN" or "DATA_FIRST" (data master wins ties).
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; 0 disables the watchdog.
- TIMEOUT_CNT_WIDTH, 8, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_CNT_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- iwbm_adr_i/dwbm_adr_i  in  ADDR_WIDTH  master address.
- iwbm_dat_i/dwbm_dat_i  in  DATA_WIDTH  master write data.
- iwbm_sel_i/dwbm_sel_i  in  DATA_WIDTH/8  byte select.
- iwbm_we_i/dwbm_we_i  in  1  write enable.
- iwbm_cyc_i/dwbm_cyc_i  in  1  cycle request.
- iwbm_stb_i/dwbm_stb_i  in  1  strobe.
- iwbm_cti_i/dwbm_cti_i  in  3  cycle type.
- iwbm_bte_i/dwbm_bte_i  in  2  burst type.
- iwbm_ack_o/dwbm_ack_o  out  1  acknowledge.
- iwbm_err_o/dwbm_err_o  out  1  error.
- iwbm_rty_o/dwbm_rty_o  out  1  retry.
- iwbm_dat_o/dwbm_dat_o  out  DATA_WIDTH  read data.
- wbs_adr_o  out  ADDR_WIDTH  slave-side address.
- wbs_dat_o  out  DATA_WIDTH  slave-side write data.
- wbs_sel_o  out  DATA_WIDTH/8  slave-side byte select.
- wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1  slave-side controls.
- wbs_cti_o  out  3  slave-side cycle type.
- wbs_bte_o  out  2  slave-side burst type.
- wbs_ack_i, wbs_err_i, wbs_rty_i  in  1  slave responses.
- wbs_dat_i  in  DATA_WIDTH  slave read data.
- grant_o  out  2  {data,instr} one-hot grant; 00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
State machine: IDLE, GNT_I, GNT_D. State and grant are registered.

Reset (rst high at a clock edge):
- state=IDLE, last_grant=I, watchdog count=0, timeout_o=0.
- All slave-side cyc/stb/we are 0 and all master-side ack/err/rty are 0 from that edge.
- Reset mid-transaction abandons the cycle immediately; no response is forwarded.

IDLE:
- Only iwbm_cyc_i high -> GNT_I next cycle. Only dwbm_cyc_i high -> GNT_D.
- Both high, ROUND_ROBIN: grant the master that is not last_grant. After reset, data therefore wins the first tie.
- Both high, DATA_FIRST: GNT_D.
- Arbitration latency is 1 cycle from cyc to slave-side cyc.

GNT_x, datapath:
- wbs_* is a combinational mux of master x's adr/dat/sel/we/cti/bte.
- wbs_cyc_o = x_cyc_i. wbs_stb_o = x_stb_i.

GNT_x, responses:
- wbs_ack_i/err_i/rty_i are routed combinationally to master x only. The other master sees 0.
- wbs_dat_i is broadcast to both *_dat_o.

GNT_x, release:
- On the edge where x_cyc_i is sampled low: if the other master's cyc is high, go directly to GNT_other (no dead cycle); otherwise go to IDLE.
- last_grant <= x on release.

GNT_x, holding:
- While x_cyc_i stays high the grant is held regardless of the other request.
- This covers bursts (cti 010) and stb-low gaps inside a cycle.

IDLE outputs:
- wbs_cyc_o=0, wbs_stb_o=0, wbs_we_o=0.
- wbs_adr/dat/sel/cti/bte are driven from the instruction master (don't-care).

Watchdog (TIMEOUT_CYCLES>0):
- The count clears on any of: a slave response, the state change, or x_stb_i low.
- Otherwise it increments each granted cycle with x_stb_i high and no response.
- When count == TIMEOUT_CYCLES-1 and still no response, in that same cycle:
  - x_err_o=1 and timeout_o=1 for exactly one cycle;
  - wbs_cyc_o and wbs_stb_o are forced 0;
  - the next state is IDLE (or the other master, if its cyc is high).
- A slave response arriving in the timeout cycle takes priority: it is forwarded and no timeout fires.
- An err pulse equal to an ack and a granted master that keeps cyc high are both legal. After the timeout release, normal arbitration applies.

Simultaneous events:
- A request from the other master in the release cycle is treated as the handover case above.
- A response arriving while IDLE is dropped.

Test Plan:
- Instruction request alone (iwbm_cyc/stb=1, adr=0x100), slave ack 2 cycles later -> wbs_cyc_o rises 1 cycle after iwbm_cyc_i, iwbm_ack_o=1 for 1 cycle, dwbm_ack_o=0, grant_o=01.
- Both cyc rise in the same cycle after reset, ROUND_ROBIN -> data granted first (grant_o=10). After dwbm_cyc_i drops, GNT_I on the next edge with no IDLE cycle. A second tie after instruction releases -> data granted.
- Instruction 8-beat burst (cti 010…111, bte 00) with dwbm_cyc_i raised at beat 3 -> all 8 acks delivered to instruction master, wbs_cti_o passes through, data granted only after iwbm_cyc_i drops.
- TIMEOUT_CYCLES=4, data read with no slave response -> dwbm_err_o=1 and timeout_o=1 in the 4th stb cycle, wbs_cyc_o=0 that cycle, grant_o=00 next cycle. Repeat with wbs_ack_i in the 4th cycle -> ack forwarded, no timeout.
- DATA_FIRST with both requesting repeatedly -> data always wins the ties. rst asserted mid-data-cycle -> next edge wbs_cyc_o=0, grant_o=00, no ack forwarded to either master.

Source files
------------

// File: rtl/mor1kx_wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone B3 arbiter.
// The grant is held for the owner's whole cyc period; a watchdog ends hung slave cycles with err.
module mor1kx_wb_arbiter #(
    parameter int    ADDR_WIDTH        = 32,
    parameter int    DATA_WIDTH        = 32,
    parameter string ARB_POLICY        = "ROUND_ROBIN",
    parameter int    TIMEOUT_CYCLES    = 255,
    parameter int    TIMEOUT_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [ADDR_WIDTH-1:0]     iwbm_adr_i,
    input  logic [DATA_WIDTH-1:0]     iwbm_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   iwbm_sel_i,
    input  logic                      iwbm_we_i,
    input  logic                      iwbm_cyc_i,
    input  logic                      iwbm_stb_i,
    input  logic [2:0]                iwbm_cti_i,
    input  logic [1:0]                iwbm_bte_i,
    output logic                      iwbm_ack_o,
    output logic                      iwbm_err_o,
    output logic                      iwbm_rty_o,
    output logic [DATA_WIDTH-1:0]     iwbm_dat_o,

    input  logic [ADDR_WIDTH-1:0]     dwbm_adr_i,
    input  logic [DATA_WIDTH-1:0]     dwbm_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   dwbm_sel_i,
    input  logic                      dwbm_we_i,
    input  logic                      dwbm_cyc_i,
    input  logic                      dwbm_stb_i,
    input  logic [2:0]                dwbm_cti_i,
    input  logic [1:0]                dwbm_bte_i,
    output logic                      dwbm_ack_o,
    output logic                      dwbm_err_o,
    output logic                      dwbm_rty_o,
    output logic [DATA_WIDTH-1:0]     dwbm_dat_o,

    output logic [ADDR_WIDTH-1:0]     wbs_adr_o,
    output logic [DATA_WIDTH-1:0]     wbs_dat_o,
    output logic [DATA_WIDTH/8-1:0]   wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    input  logic [DATA_WIDTH-1:0]     wbs_dat_i,

    output logic [1:0]                grant_o,
    output logic                      timeout_o
);

    // State encoding doubles as the {data,instr} one-hot grant.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;

    localparam bit DATA_FIRST = (ARB_POLICY == "DATA_FIRST");
    localparam bit WD_EN      = (TIMEOUT_CYCLES > 0);
    localparam logic [TIMEOUT_CNT_WIDTH-1:0] WD_LAST =
        TIMEOUT_CNT_WIDTH'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]                   state_q, state_d;
    logic                         last_d_q, last_d_d;   // 1: data master held the last grant
    logic [TIMEOUT_CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

    logic gnt_i, gnt_d, granted;
    logic own_cyc, own_stb, own_we, oth_cyc;
    logic resp, wd_fire;

    always_comb begin
        gnt_i   = (state_q == GNT_I);
        gnt_d   = (state_q == GNT_D);
        granted = gnt_i | gnt_d;
        own_cyc = gnt_d ? dwbm_cyc_i : iwbm_cyc_i;
        own_stb = gnt_d ? dwbm_stb_i : iwbm_stb_i;
        own_we  = gnt_d ? dwbm_we_i  : iwbm_we_i;
        oth_cyc = gnt_d ? iwbm_cyc_i : dwbm_cyc_i;
        resp    = wbs_ack_i | wbs_err_i | wbs_rty_i;
        // A response in the limit cycle wins over the watchdog.
        wd_fire = WD_EN && granted && own_cyc && own_stb && !resp && (wd_cnt_q == WD_LAST);
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        case (state_q)
            IDLE: begin
                if (iwbm_cyc_i && dwbm_cyc_i)
                    state_d = (DATA_FIRST || !last_d_q) ? GNT_D : GNT_I;
                else if (dwbm_cyc_i)
                    state_d = GNT_D;
                else if (iwbm_cyc_i)
                    state_d = GNT_I;
            end
            GNT_I, GNT_D: begin
                // Release hands straight over to a waiting master, no dead cycle.
                if (!own_cyc || wd_fire) begin
                    last_d_d = gnt_d;
                    if (oth_cyc)
                        state_d = gnt_d ? GNT_I : GNT_D;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (!WD_EN || !granted || !own_stb || resp || (state_d != state_q))
            wd_cnt_d = '0;
        else
            wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    always_comb begin
        wbs_adr_o = gnt_d ? dwbm_adr_i : iwbm_adr_i;
        wbs_dat_o = gnt_d ? dwbm_dat_i : iwbm_dat_i;
        wbs_sel_o = gnt_d ? dwbm_sel_i : iwbm_sel_i;
        wbs_cti_o = gnt_d ? dwbm_cti_i : iwbm_cti_i;
        wbs_bte_o = gnt_d ? dwbm_bte_i : iwbm_bte_i;
        wbs_we_o  = granted & own_we;
        wbs_cyc_o = granted & own_cyc & ~wd_fire;
        wbs_stb_o = granted & own_stb & ~wd_fire;

        iwbm_ack_o = gnt_i & wbs_ack_i;
        iwbm_err_o = gnt_i & (wbs_err_i | wd_fire);
        iwbm_rty_o = gnt_i & wbs_rty_i;
        dwbm_ack_o = gnt_d & wbs_ack_i;
        dwbm_err_o = gnt_d & (wbs_err_i | wd_fire);
        dwbm_rty_o = gnt_d & wbs_rty_i;
        iwbm_dat_o = wbs_dat_i;
        dwbm_dat_o = wbs_dat_i;

        grant_o   = state_q;
        timeout_o = wd_fire;
    end

endmodule

// File: tb/tb_mor1kx_wb_arbiter.sv
// Directed bench for mor1kx_wb_arbiter: round-robin and data-first instances share stimulus.
module tb_mor1kx_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] iadr, idat, dadr, ddat, sdat;
    logic [3:0]  isel, dsel;
    logic        iwe, dwe, ic, is, dc, ds, ack, err, rty;
    logic [2:0]  icti, dcti;
    logic [1:0]  ibte, dbte;

    logic        iack_r, ierr_r, irty_r, dack_r, derr_r, drty_r;
    logic [31:0] idato_r, ddato_r, sadr_r, sdato_r;
    logic [3:0]  ssel_r;
    logic        swe_r, scyc_r, sstb_r, to_r;
    logic [2:0]  scti_r;
    logic [1:0]  sbte_r, gnt_r;

    logic        iack_f, ierr_f, irty_f, dack_f, derr_f, drty_f;
    logic [31:0] idato_f, ddato_f, sadr_f, sdato_f;
    logic [3:0]  ssel_f;
    logic        swe_f, scyc_f, sstb_f, to_f;
    logic [2:0]  scti_f;
    logic [1:0]  sbte_f, gnt_f;

    mor1kx_wb_arbiter #(.ARB_POLICY("ROUND_ROBIN"), .TIMEOUT_CYCLES(4), .TIMEOUT_CNT_WIDTH(3)) dut_rr (
        .clk(clk), .rst(rst),
        .iwbm_adr_i(iadr), .iwbm_dat_i(idat), .iwbm_sel_i(isel), .iwbm_we_i(iwe),
        .iwbm_cyc_i(ic), .iwbm_stb_i(is), .iwbm_cti_i(icti), .iwbm_bte_i(ibte),
        .iwbm_ack_o(iack_r), .iwbm_err_o(ierr_r), .iwbm_rty_o(irty_r), .iwbm_dat_o(idato_r),
        .dwbm_adr_i(dadr), .dwbm_dat_i(ddat), .dwbm_sel_i(dsel), .dwbm_we_i(dwe),
        .dwbm_cyc_i(dc), .dwbm_stb_i(ds), .dwbm_cti_i(dcti), .dwbm_bte_i(dbte),
        .dwbm_ack_o(dack_r), .dwbm_err_o(derr_r), .dwbm_rty_o(drty_r), .dwbm_dat_o(ddato_r),
        .wbs_adr_o(sadr_r), .wbs_dat_o(sdato_r), .wbs_sel_o(ssel_r), .wbs_we_o(swe_r),
        .wbs_cyc_o(scyc_r), .wbs_stb_o(sstb_r), .wbs_cti_o(scti_r), .wbs_bte_o(sbte_r),
        .wbs_ack_i(ack), .wbs_err_i(err), .wbs_rty_i(rty), .wbs_dat_i(sdat),
        .grant_o(gnt_r), .timeout_o(to_r)
    );

    mor1kx_wb_arbiter #(.ARB_POLICY("DATA_FIRST"), .TIMEOUT_CYCLES(4), .TIMEOUT_CNT_WIDTH(3)) dut_df (
        .clk(clk), .rst(rst),
        .iwbm_adr_i(iadr), .iwbm_dat_i(idat), .iwbm_sel_i(isel), .iwbm_we_i(iwe),
        .iwbm_cyc_i(ic), .iwbm_stb_i(is), .iwbm_cti_i(icti), .iwbm_bte_i(ibte),
        .iwbm_ack_o(iack_f), .iwbm_err_o(ierr_f), .iwbm_rty_o(irty_f), .iwbm_dat_o(idato_f),
        .dwbm_adr_i(dadr), .dwbm_dat_i(ddat), .dwbm_sel_i(dsel), .dwbm_we_i(dwe),
        .dwbm_cyc_i(dc), .dwbm_stb_i(ds), .dwbm_cti_i(dcti), .dwbm_bte_i(dbte),
        .dwbm_ack_o(dack_f), .dwbm_err_o(derr_f), .dwbm_rty_o(drty_f), .dwbm_dat_o(ddato_f),
        .wbs_adr_o(sadr_f), .wbs_dat_o(sdato_f), .wbs_sel_o(ssel_f), .wbs_we_o(swe_f),
        .wbs_cyc_o(scyc_f), .wbs_stb_o(sstb_f), .wbs_cti_o(scti_f), .wbs_bte_o(sbte_f),
        .wbs_ack_i(ack), .wbs_err_i(err), .wbs_rty_i(rty), .wbs_dat_i(sdat),
        .grant_o(gnt_f), .timeout_o(to_f)
    );

    // in:  {ic, is, dc, ds, ack, err, rty}
    // flg: {wbs_cyc, wbs_stb, iack, dack, ierr, derr, irty, drty, timeout}
    typedef struct {
        logic [6:0] in;
        logic [8:0] flg;
        logic [1:0] gnt;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];
    int n_chk = 0;
    int n_fail = 0;

    function automatic vec_t mk(input logic [6:0] in, input logic [8:0] flg, input logic [1:0] gnt);
        vec_t v;
        v.in = in; v.flg = flg; v.gnt = gnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] in);
        {ic, is, dc, ds, ack, err, rty} = in;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; set_in(7'b0);
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    logic [8:0] flg_r;
    assign flg_r = {scyc_r, sstb_r, iack_r, dack_r, ierr_r, derr_r, irty_r, drty_r, to_r};

    initial begin
        iadr = 32'h0000_0100; dadr = 32'h0000_0200;
        idat = 32'h1111_0000; ddat = 32'h2222_0000; sdat = 32'hCAFE_0001;
        isel = 4'hF; dsel = 4'h3; iwe = 1'b0; dwe = 1'b1;
        icti = 3'b000; dcti = 3'b000; ibte = 2'b00; dbte = 2'b00;
        rst = 1'b0; set_in(7'b0);

        tbl[0]  = mk(7'b0000000, 9'b000000000, 2'b00);  // reset state
        tbl[1]  = mk(7'b1100000, 9'b000000000, 2'b00);  // arbitration cycle
        tbl[2]  = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[3]  = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[4]  = mk(7'b1100100, 9'b111000000, 2'b01);  // ack to instr only
        tbl[5]  = mk(7'b0000000, 9'b000000000, 2'b01);
        tbl[6]  = mk(7'b0000000, 9'b000000000, 2'b00);
        tbl[7]  = mk(7'b1111000, 9'b000000000, 2'b00);  // tie, last=I -> data
        tbl[8]  = mk(7'b1111000, 9'b110000000, 2'b10);
        tbl[9]  = mk(7'b1111100, 9'b110100000, 2'b10);
        tbl[10] = mk(7'b1100000, 9'b000000000, 2'b10);  // data releases, instr waiting
        tbl[11] = mk(7'b1100000, 9'b110000000, 2'b01);  // no idle gap
        tbl[12] = mk(7'b1100010, 9'b110010000, 2'b01);  // err routed
        tbl[13] = mk(7'b0000000, 9'b000000000, 2'b01);
        tbl[14] = mk(7'b1111000, 9'b000000000, 2'b00);  // second tie -> data
        tbl[15] = mk(7'b1111001, 9'b110000010, 2'b10);  // rty routed
        tbl[16] = mk(7'b0000000, 9'b000000000, 2'b10);
        tbl[17] = mk(7'b0011000, 9'b000000000, 2'b00);  // data read, hung slave
        tbl[18] = mk(7'b0011000, 9'b110000000, 2'b10);
        tbl[19] = mk(7'b0011000, 9'b110000000, 2'b10);
        tbl[20] = mk(7'b0011000, 9'b110000000, 2'b10);
        tbl[21] = mk(7'b0011000, 9'b000001001, 2'b10);  // 4th stb cycle: timeout
        tbl[22] = mk(7'b0011000, 9'b000000000, 2'b00);
        tbl[23] = mk(7'b0011000, 9'b110000000, 2'b10);
        tbl[24] = mk(7'b0011000, 9'b110000000, 2'b10);
        tbl[25] = mk(7'b0011000, 9'b110000000, 2'b10);
        tbl[26] = mk(7'b0011100, 9'b110100000, 2'b10);  // ack in limit cycle wins
        tbl[27] = mk(7'b0000000, 9'b000000000, 2'b10);
        tbl[28] = mk(7'b0000100, 9'b000000000, 2'b00);  // ack while idle dropped
        tbl[29] = mk(7'b1100000, 9'b000000000, 2'b00);
        tbl[30] = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[31] = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[32] = mk(7'b1000000, 9'b100000000, 2'b01);  // stb gap clears watchdog
        tbl[33] = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[34] = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[35] = mk(7'b1100000, 9'b110000000, 2'b01);
        tbl[36] = mk(7'b1100000, 9'b000010001, 2'b01);  // instr timeout
        tbl[37] = mk(7'b0000000, 9'b000000000, 2'b00);

        do_reset();

        for (int r = 0; r < NV; r++) begin
            @(negedge clk); set_in(tbl[r].in);
            #2;
            chk($sformatf("row%0d flags", r), 32'(flg_r), 32'(tbl[r].flg));
            chk($sformatf("row%0d grant", r), 32'(gnt_r), 32'(tbl[r].gnt));
            chk($sformatf("row%0d adr", r), sadr_r, (tbl[r].gnt == 2'b10) ? dadr : iadr);
            chk($sformatf("row%0d we", r), 32'(swe_r), (tbl[r].gnt == 2'b10) ? 32'd1 : 32'd0);
            chk($sformatf("row%0d dat", r), {idato_r ^ ddato_r}, 32'd0);
            chk($sformatf("row%0d idat", r), idato_r, sdat);
        end

        // Instruction 8-beat incrementing burst; data requests from beat 3.
        @(negedge clk); set_in(7'b1100000); icti = 3'b010;
        #2; chk("burst arb grant", 32'(gnt_r), 32'd0);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            icti = (b == 7) ? 3'b111 : 3'b010;
            set_in({2'b11, (b >= 3) ? 2'b11 : 2'b00, 3'b100});
            #2;
            chk($sformatf("burst%0d iack", b), 32'(iack_r), 32'd1);
            chk($sformatf("burst%0d dack", b), 32'(dack_r), 32'd0);
            chk($sformatf("burst%0d grant", b), 32'(gnt_r), 32'd1);
            chk($sformatf("burst%0d cti", b), 32'(scti_r), (b == 7) ? 32'd7 : 32'd2);
        end
        @(negedge clk); set_in(7'b0011000); icti = 3'b000;
        #2; chk("burst release grant", 32'(gnt_r), 32'd1);
        chk("burst release cyc", 32'(scyc_r), 32'd0);
        @(negedge clk); set_in(7'b0011100);
        #2; chk("burst handover grant", 32'(gnt_r), 32'd2);
        chk("burst handover dack", 32'(dack_r), 32'd1);
        @(negedge clk); set_in(7'b0000000);

        // Repeated ties: data-first always picks data, round-robin alternates.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); set_in(7'b1111000);
            #2; chk($sformatf("tie%0d df idle", k), 32'(gnt_f), 32'd0);
            @(negedge clk);
            #2; chk($sformatf("tie%0d df grant", k), 32'(gnt_f), 32'd2);
            chk($sformatf("tie%0d rr grant", k), 32'(gnt_r), (k == 1) ? 32'd1 : 32'd2);
            @(negedge clk); set_in(7'b0000000);
        end

        // Reset in the middle of a data cycle.
        @(negedge clk); set_in(7'b0011000);
        @(negedge clk);
        #2; chk("pre-rst grant", 32'(gnt_f), 32'd2);
        chk("pre-rst cyc", 32'(scyc_r), 32'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; set_in(7'b0011100);
        #2;
        chk("rst rr cyc", 32'(scyc_r), 32'd0);
        chk("rst rr grant", 32'(gnt_r), 32'd0);
        chk("rst rr acks", 32'({iack_r, dack_r}), 32'd0);
        chk("rst df cyc", 32'(scyc_f), 32'd0);
        chk("rst df grant", 32'(gnt_f), 32'd0);
        chk("rst df acks", 32'({iack_f, dack_f}), 32'd0);
        @(negedge clk); set_in(7'b0000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
